// File: rtl/uart_cmd_rx_if.sv
// Serial line plus decoded byte/command strobes of the UART command receiver.
// The slave modport is the receiver side; master is whoever drives rx and consumes the pulses.
interface uart_cmd_rx_if;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       start_cmd;
    logic       p1_cmd;
    logic       p2_cmd;
    logic       cmd_err;
    logic       busy;

    modport master (
        output rx,
        input  rx_byte, rx_valid, frame_err, start_cmd, p1_cmd, p2_cmd, cmd_err, busy
    );

    modport slave (
        input  rx,
        output rx_byte, rx_valid, frame_err, start_cmd, p1_cmd, p2_cmd, cmd_err, busy
    );
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 oversampling UART receiver with a line decoder for the "S"/"1"/"2" remote commands.
// Define UART_CMD_NOCASE_EN to fold lowercase letters to uppercase before they reach the line buffer.
module uart_cmd_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int MAX_LEN    = 4
) (
    input logic           clk,
    input logic           reset,
    uart_cmd_rx_if.slave  bus
);
    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TC_W  = $clog2(OVERSAMPLE);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [TC_W-1:0]  TC_MID   = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0]  TC_END   = TC_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef UART_CMD_NOCASE_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
        return b;
    endfunction

    logic [1:0]       sync_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [TC_W-1:0]  tc_q, tc_d;
    logic [2:0]       bc_q, bc_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q;
    logic             rx_valid_q, frame_err_q;
    logic             busy, byte_done, stop_bad;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       first_q, first_d;
    logic             bad_q, bad_d;
    logic             start_q, start_d, p1_q, p1_d, p2_q, p2_d, cerr_q, cerr_d;

    assign rx_s = sync_q[1];
    assign tick = (div_q == DIV_LAST);
    // Realign the baud phase to the falling edge of each start bit.
    assign div_d = ((state_q == S_IDLE && !rx_s) || tick) ? '0 : div_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            div_q       <= '0;
            state_q     <= S_IDLE;
            tc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            len_q       <= '0;
            first_q     <= '0;
            bad_q       <= 1'b0;
            start_q     <= 1'b0;
            p1_q        <= 1'b0;
            p2_q        <= 1'b0;
            cerr_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], bus.rx};
            div_q       <= div_d;
            state_q     <= state_d;
            tc_q        <= tc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            if (byte_done) rx_byte_q <= shift_q;
            rx_valid_q  <= byte_done;
            frame_err_q <= stop_bad;
            len_q       <= len_d;
            first_q     <= first_d;
            bad_q       <= bad_d;
            start_q     <= start_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            cerr_q      <= cerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        bc_d    = bc_q;
        shift_d = shift_q;
        case (state_q)
            S_IDLE: if (!rx_s) begin
                state_d = S_START;
                tc_d    = '0;
            end
            S_START: if (tick) begin
                if (tc_q == TC_MID) begin
                    tc_d    = '0;
                    bc_d    = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else tc_d = tc_q + 1'b1;
            end
            S_DATA: if (tick) begin
                if (tc_q == TC_END) begin
                    tc_d    = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bc_d    = bc_q + 3'd1;
                    if (bc_q == 3'd7) state_d = S_STOP;
                end else tc_d = tc_q + 1'b1;
            end
            S_STOP: if (tick) begin
                if (tc_q == TC_END) begin
                    tc_d    = '0;
                    state_d = rx_s ? S_IDLE : S_BREAK;
                end else tc_d = tc_q + 1'b1;
            end
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        byte_done = (state_q == S_STOP) && tick && (tc_q == TC_END) && rx_s;
        stop_bad  = (state_q == S_STOP) && tick && (tc_q == TC_END) && !rx_s;
    end

    // Only buf[0] is ever decoded, so the line buffer keeps just its first slot plus the length.
    always_comb begin
        len_d   = len_q;
        first_d = first_q;
        bad_d   = bad_q;
        start_d = 1'b0;
        p1_d    = 1'b0;
        p2_d    = 1'b0;
        cerr_d  = 1'b0;
        if (rx_valid_q) begin
            if (rx_byte_q == 8'h0D || rx_byte_q == 8'h0A) begin
                if (len_q != '0 || bad_q) begin
                    if (!bad_q && len_q == LEN_W'(1)) begin
                        case (first_q)
                            8'h53:   start_d = 1'b1;
                            8'h31:   p1_d    = 1'b1;
                            8'h32:   p2_d    = 1'b1;
                            default: cerr_d  = 1'b1;
                        endcase
                    end else cerr_d = 1'b1;
                end
                len_d = '0;
                bad_d = 1'b0;
            end else if (rx_byte_q == 8'h08) begin
                if (len_q != '0) len_d = len_q - 1'b1;
            end else if (len_q < LEN_W'(MAX_LEN)) begin
                if (len_q == '0) first_d = fold_case(rx_byte_q);
                len_d = len_q + 1'b1;
            end else bad_d = 1'b1;
        end
        if (frame_err_q) bad_d = 1'b1;
    end

    assign bus.rx_byte   = rx_byte_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.start_cmd = start_q;
    assign bus.p1_cmd    = p1_q;
    assign bus.p2_cmd    = p2_q;
    assign bus.cmd_err   = cerr_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed plus randomized bench for uart_cmd_rx; command outcomes come from a queue-based line model.
module tb_uart_cmd_rx;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int MAX_LEN  = 4;
    localparam int BIT_CLK  = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_cmd_rx_if bus();

    uart_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc = 0, n_rxv = 0, n_fe = 0, n_st = 0, n_p1 = 0, n_p2 = 0, n_ce = 0;
    int n_multi = 0, last_rxv = 0, last_delta = 0;
    logic [7:0] rxq[$];
    logic [7:0] line_q[$];

    always @(negedge clk) begin
        int hi;
        cyc++;
        hi = int'(bus.start_cmd) + int'(bus.p1_cmd) + int'(bus.p2_cmd) + int'(bus.cmd_err);
        if (bus.rx_valid) begin
            rxq.push_back(bus.rx_byte);
            n_rxv++;
            last_rxv = cyc;
        end
        if (bus.frame_err) n_fe++;
        if (bus.start_cmd) n_st++;
        if (bus.p1_cmd) n_p1++;
        if (bus.p2_cmd) n_p2++;
        if (bus.cmd_err) n_ce++;
        if (hi > 0) last_delta = cyc - last_rxv;
        if (hi > 1) n_multi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef UART_CMD_NOCASE_EN
        if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
        return c;
    endfunction

    // 0 = silent, 1 = start, 2 = P1, 3 = P2, 4 = cmd_err
    function automatic int model_line(input bit fe);
        logic [7:0] q[$];
        bit badf;
        badf = fe;
        foreach (line_q[i]) begin
            if (line_q[i] == 8'h08) begin
                if (q.size() > 0) void'(q.pop_back());
            end else if (q.size() < MAX_LEN) q.push_back(fold(line_q[i]));
            else badf = 1'b1;
        end
        if (q.size() == 0 && !badf) return 0;
        if (badf || q.size() != 1) return 4;
        case (q[0])
            8'h53:   return 1;
            8'h31:   return 2;
            8'h32:   return 3;
            default: return 4;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        bus.rx = stop;
        repeat (BIT_CLK) @(negedge clk);
        if (stop) repeat (20) @(negedge clk);
    endtask

    task automatic run_line(input logic [7:0] term, input bit fe, input string tag);
        int s0, a0, b0, e0, r0, nb, exp;
        s0 = n_st; a0 = n_p1; b0 = n_p2; e0 = n_ce; r0 = n_rxv;
        exp = model_line(fe);
        nb  = line_q.size();
        rxq.delete();
        foreach (line_q[i]) send_byte(line_q[i], 1'b1);
        send_byte(term, 1'b1);
        repeat (5) @(negedge clk);
        chk({tag, "_nrx"}, n_rxv - r0, nb + 1);
        for (int i = 0; i < nb && i < rxq.size(); i++)
            chk({tag, "_byte"}, rxq[i], line_q[i]);
        chk({tag, "_term"}, bus.rx_byte, term);
        chk({tag, "_start"}, n_st - s0, (exp == 1));
        chk({tag, "_p1"}, n_p1 - a0, (exp == 2));
        chk({tag, "_p2"}, n_p2 - b0, (exp == 3));
        chk({tag, "_err"}, n_ce - e0, (exp == 4));
        if (exp != 0) chk({tag, "_lat"}, last_delta, 1);
    endtask

    initial begin
        int r0, f0, nl;
        logic [7:0] alpha[7];
        logic [7:0] term;
        alpha = '{8'h53, 8'h73, 8'h31, 8'h32, 8'h41, 8'h08, 8'h7A};
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_outs", {bus.rx_byte, bus.rx_valid, bus.frame_err, bus.start_cmd,
                         bus.p1_cmd, bus.p2_cmd, bus.cmd_err, bus.busy}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        line_q = '{8'h53};               run_line(8'h0D, 1'b0, "S_cr");
        line_q = '{8'h32};               run_line(8'h0D, 1'b0, "2_cr");
        line_q.delete();                 run_line(8'h0A, 1'b0, "lf_only");
        line_q = '{8'h31, 8'h08, 8'h32}; run_line(8'h0D, 1'b0, "bksp");
        line_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45}; run_line(8'h0D, 1'b0, "ovf");
        line_q = '{8'h31};               run_line(8'h0D, 1'b0, "1_cr");

        // Framing error: stop bit low, line held in break, then an otherwise empty line.
        r0 = n_rxv; f0 = n_fe;
        send_byte(8'h31, 1'b0);
        repeat (400) @(negedge clk);
        chk("brk_busy", bus.busy, 1'b1);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("brk_idle", bus.busy, 1'b0);
        chk("brk_fe", n_fe - f0, 1);
        chk("brk_norx", n_rxv - r0, 0);
        line_q.delete();                 run_line(8'h0D, 1'b1, "fe_cr");

        // Short low glitch on an idle line.
        r0 = n_rxv; f0 = n_fe;
        bus.rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("gl_busy", bus.busy, 1'b1);
        repeat (30) @(negedge clk);
        bus.rx = 1'b1;
        repeat (150) @(negedge clk);
        chk("gl_idle", bus.busy, 1'b0);
        chk("gl_norx", n_rxv - r0, 0);
        chk("gl_nofe", n_fe - f0, 0);

        // Reset in the middle of data bit 4 of 0x5A.
        r0 = n_rxv;
        term = 8'h5A;
        bus.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.rx = term[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_byte", bus.rx_byte, 8'h00);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        chk("mrst_norx", n_rxv - r0, 0);
        line_q = '{8'h53};               run_line(8'h0D, 1'b0, "post_rst");
        line_q = '{8'h73};               run_line(8'h0D, 1'b0, "lower_s");

        for (int l = 0; l < 3; l++) begin
            line_q.delete();
            nl = $urandom_range(0, 4);
            for (int k = 0; k < nl; k++) line_q.push_back(alpha[$urandom_range(0, 6)]);
            term = ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A;
            run_line(term, 1'b0, "rand");
        end

        chk("one_hot", n_multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
